// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// if_fetch_if : instruction-memory request/response channel of the fetch stage
// Rev 1.0
// ============================================================================
interface if_fetch_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;

  modport master (
    output if_req_valid,
    output if_req_addr,
    input  if_req_ready,
    input  if_resp_valid,
    input  if_resp_data
  );

  modport slave (
    input  if_req_valid,
    input  if_req_addr,
    output if_req_ready,
    output if_resp_valid,
    output if_resp_data
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// if_fetch : RV64 instruction-fetch stage, one outstanding imem request,
//            skid for back-pressured responses, redirect with in-flight drop
// Rev 1.0
// ============================================================================
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  if_fetch_if.master  imem,
  input  logic        stall_if,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pc_id,
  output logic [31:0] inst_id,
  output logic        valid_id
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc_fetch;
  logic [63:0] r_skid_pc;
  logic [31:0] r_skid_inst;

  logic        w_out_free;
  logic        w_load;
  logic [63:0] w_load_pc;
  logic [31:0] w_load_inst;
  logic [63:0] w_redirect_target;

  assign imem.if_req_valid = (r_state == S_REQ) && !redirect;
  assign imem.if_req_addr  = r_pc_fetch;

  assign w_out_free        = !valid_id || !stall_if;
  assign w_redirect_target = redirect_pc & ~64'd3;

  // Selects what (if anything) enters the IF/ID register this cycle.
  always_comb begin
    w_load      = 1'b0;
    w_load_pc   = r_pc_fetch;
    w_load_inst = imem.if_resp_data;
    if (r_state == S_WAIT && imem.if_resp_valid && w_out_free) begin
      w_load = 1'b1;
    end else if (r_state == S_HOLD && w_out_free) begin
      w_load      = 1'b1;
      w_load_pc   = r_skid_pc;
      w_load_inst = r_skid_inst;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_REQ;
      r_pc_fetch  <= RESET_PC;
      r_skid_pc   <= 64'd0;
      r_skid_inst <= 32'd0;
      pc_id       <= 64'd0;
      inst_id     <= 32'd0;
      valid_id    <= 1'b0;
    end else if (redirect) begin
      r_pc_fetch  <= w_redirect_target;
      r_skid_pc   <= 64'd0;
      r_skid_inst <= 32'd0;
      valid_id    <= 1'b0;
      case (r_state)
        S_WAIT:  r_state <= imem.if_resp_valid ? S_REQ : S_DRAIN;
        S_DRAIN: r_state <= imem.if_resp_valid ? S_REQ : S_DRAIN;
        default: r_state <= S_REQ;
      endcase
    end else begin
      if (w_load) begin
        pc_id    <= w_load_pc;
        inst_id  <= w_load_inst;
        valid_id <= 1'b1;
      end else if (!stall_if) begin
        valid_id <= 1'b0;
      end

      case (r_state)
        S_REQ: begin
          if (imem.if_req_valid && imem.if_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.if_resp_valid) begin
            r_pc_fetch <= r_pc_fetch + 64'd4;
            if (w_out_free) begin
              r_state <= S_REQ;
            end else begin
              // Decode is stalled on a live instruction: park the word.
              r_skid_pc   <= r_pc_fetch;
              r_skid_inst <= imem.if_resp_data;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_out_free) begin
            r_state <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem.if_resp_valid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// tb_if_fetch : randomized scoreboard bench; the model says the consumed
// instruction stream is sequential from the last redirect/reset target.
module tb_if_fetch;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall_if;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] pc_id;
  logic [31:0] inst_id;
  logic        valid_id;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .imem       (bus),
    .stall_if   (stall_if),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc_id      (pc_id),
    .inst_id    (inst_id),
    .valid_id   (valid_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] gen_pc;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_consumed = 0;
  int          cyc = 0;
  int          cons_cyc0 = -1;
  int          cons_cyc1 = -1;
  int          first_acc_cyc = -1;
  int          p_ready, p_stall, p_redir, lat_min, lat_max;
  bit          first_req_chk = 0;
  bit          force_redir = 0;
  logic [63:0] force_target;

  // imem model state
  bit          pend;
  int          cnt;
  logic [63:0] paddr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    w = a[33:2] * 32'h9E37_79B1;
    return w ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid_id"}, 64'(valid_id), 64'd0);
    chk({tag, "_pc_id"}, pc_id, 64'd0);
    chk({tag, "_inst_id"}, 64'(inst_id), 64'd0);
    chk({tag, "_req_valid"}, 64'(bus.if_req_valid), 64'd1);
    chk({tag, "_req_addr"}, bus.if_req_addr, RESET_PC);
  endtask

  function automatic logic [63:0] pick_target();
    if ($urandom_range(3) == 0)
      return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
    return {$urandom, $urandom};
  endfunction

  // One clock of stimulus: drive at posedge+1, sample acceptance at negedge.
  task automatic step();
    logic        acc;
    logic [63:0] aaddr;
    bus.if_resp_valid = pend && (cnt == 0);
    bus.if_resp_data  = bus.if_resp_valid ? mem_word(paddr) : $urandom;
    bus.if_req_ready  = ($urandom_range(99) < p_ready);
    stall_if          = ($urandom_range(99) < p_stall);
    redirect          = force_redir || ($urandom_range(99) < p_redir);
    if (redirect) begin
      redirect_pc = force_redir ? force_target : pick_target();
      force_redir = 0;
      exp_q.delete();
      gen_pc = redirect_pc & ~64'd3;
    end else begin
      redirect_pc = {$urandom, $urandom};
    end
    while (exp_q.size() < 16) begin
      exp_q.push_back('{pc: gen_pc, inst: mem_word(gen_pc)});
      gen_pc = gen_pc + 64'd4;
    end
    @(negedge clk);
    acc   = bus.if_req_valid && bus.if_req_ready;
    aaddr = bus.if_req_addr;
    if (acc) begin
      chk("single_outstanding", 64'(pend), 64'd0);
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      if (first_req_chk) begin
        chk("first_req_after_reset", aaddr, RESET_PC);
        first_req_chk = 0;
      end
    end
    @(posedge clk);
    #1;
    if (bus.if_resp_valid) pend = 0;
    else if (pend) cnt--;
    if (acc) begin
      pend  = 1;
      cnt   = $urandom_range(lat_max, lat_min) - 1;
      paddr = aaddr;
    end
  endtask

  // Monitor: pops the scoreboard whenever decode consumes an instruction.
  initial begin
    exp_t        e;
    bit          prev_blocked = 0;
    bit          prev_redir = 0;
    logic [63:0] prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_blocked = 0;
        prev_redir   = 0;
      end else begin
        if (bus.if_req_valid) chk("req_addr_aligned", 64'(bus.if_req_addr[1:0]), 64'd0);
        if (redirect) chk("req_valid_during_redirect", 64'(bus.if_req_valid), 64'd0);
        if (prev_redir) chk("valid_id_after_redirect", 64'(valid_id), 64'd0);
        if (prev_blocked && bus.if_req_valid) chk("req_addr_stable", bus.if_req_addr, prev_addr);
        if (valid_id && !stall_if && !redirect) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 64'd0, 64'd1);
          end else begin
            e = exp_q.pop_front();
            chk("pc_id", pc_id, e.pc);
            chk("inst_id", 64'(inst_id), 64'(e.inst));
          end
          if (n_consumed == 0) cons_cyc0 = cyc;
          if (n_consumed == 1) cons_cyc1 = cyc;
          n_consumed++;
        end
        prev_blocked = bus.if_req_valid && !bus.if_req_ready;
        prev_addr    = bus.if_req_addr;
        prev_redir   = redirect;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, consumed=%0d", n_consumed);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 0;
    bus.if_req_ready = 0;
    bus.if_resp_valid = 0;
    bus.if_resp_data = 0;
    stall_if = 0;
    redirect = 0;
    redirect_pc = 0;
    pend = 0;
    cnt = 0;
    paddr = 0;
    gen_pc = RESET_PC;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rstn = 1;

    // Directed: ready=1, no stall, 1-cycle imem -> latency 2, one per 2 cycles.
    p_ready = 100; p_stall = 0; p_redir = 0; lat_min = 1; lat_max = 1;
    repeat (10) step();
    chk("latency_acc_to_valid", 64'(cons_cyc0 - first_acc_cyc), 64'd2);
    chk("throughput_gap", 64'(cons_cyc1 - cons_cyc0), 64'd2);

    // Directed: top-of-memory wrap, with some stall pressure.
    p_stall = 30;
    force_redir = 1;
    force_target = 64'hFFFF_FFFF_FFFF_FFFE;
    repeat (20) step();

    // Randomized traffic.
    p_ready = 70; p_stall = 40; p_redir = 6; lat_min = 1; lat_max = 3;
    repeat (3000) step();

    // Reset while a request is outstanding.
    for (int i = 0; i < 100 && !pend; i++) step();
    chk("reset_point_outstanding", 64'(pend), 64'd1);
    #1;
    rstn = 0;
    bus.if_req_ready = 0;
    bus.if_resp_valid = 0;
    stall_if = 0;
    redirect = 0;
    pend = 0;
    #1;
    check_reset("midwait_reset");
    exp_q.delete();
    gen_pc = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    first_req_chk = 1;
    repeat (1000) step();
    chk("first_req_after_reset_seen", 64'(first_req_chk), 64'd0);
    chk("progress", 64'(n_consumed >= 200), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
